// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its downstream drain stages.
//   uart_tx_state_t           : fifo_uart_tx FSM state encoding
//   UART_DATA_BITS            : data bits per UART frame
//   UART_DEFAULT_CLKS_PER_BIT : default bit period in clock cycles
package fifo_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } uart_tx_state_t;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer for the UART transmitter.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   clear : holds the timer at 0 (used while no bit is on the line)
//   tick  : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear || tick) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from the FIFO read port and sends each as an
// 8N1 UART frame (start bit, 8 data bits LSB first, stop bit).
//   clk          : system clock
//   rst          : synchronous reset, active-high
//   tx_en        : permits new frames to start; a frame in flight always completes
//   fifo_empty   : FIFO has no data
//   fifo_rd_data : FIFO read data, valid the cycle after fifo_pop
//   fifo_pop     : one-cycle read strobe to the FIFO
//   tx           : UART line, idles high
//   busy         : high from the pop cycle through the last stop-bit cycle
//   sent_count   : completed frames, wraps at 256
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_count
);

    localparam logic [2:0] LastBitIdx = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     sent_q, sent_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           tick;
    logic           timer_clear;

    // Timer only runs while a bit is on the line; LOAD leaves it at 0 so the
    // start bit gets a full period.
    assign timer_clear = (state_q == StIdle) || (state_q == StLoad);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    // Gated by rst so no pop escapes while the block is being reset.
    assign fifo_pop = !rst && (state_q == StIdle) && tx_en && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        sent_d    = sent_q;

        unique case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shreg_d   = fifo_rd_data;
                bit_idx_d = 3'd0;
                state_d   = StStart;
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LastBitIdx) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so tx changes on the
        // same edge that enters each bit.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            sent_q    <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            sent_q    <= sent_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx         = tx_q;
    // The pop cycle is still IDLE in the register, so fold the strobe in.
    assign busy       = busy_q | fifo_pop;
    assign sent_count = sent_q;

endmodule
